// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit frame sequencer: FSM states, line-select codes,
// parity type constants.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } tx_state_e;

  localparam logic [1:0] TxSelStart  = 2'b00;
  localparam logic [1:0] TxSelData   = 2'b01;
  localparam logic [1:0] TxSelParity = 2'b10;
  localparam logic [1:0] TxSelStop   = 2'b11;

  localparam logic ParEven = 1'b0;
  localparam logic ParOdd  = 1'b1;

  // Idle shares the stop code: both hold the line high.
  function automatic logic [1:0] tx_sel_of(tx_state_e st);
    logic [1:0] sel;
    sel = TxSelStop;
    case (st)
      StStart:  sel = TxSelStart;
      StData:   sel = TxSelData;
      StParity: sel = TxSelParity;
      default:  sel = TxSelStop;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Byte-in handshake between a data source and the UART transmit sequencer.
interface uart_tx_ctrl_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic [WIDTH-1:0] P_DATA;
  logic             data_valid;
  logic             data_ready;
  logic             par_en;
  logic             par_typ;

  modport master (
    output P_DATA,
    output data_valid,
    output par_en,
    output par_typ,
    input  data_ready
  );

  modport slave (
    input  P_DATA,
    input  data_valid,
    input  par_en,
    input  par_typ,
    output data_ready
  );
endinterface

// File: rtl/parity_calc.sv
// Parity bit for one byte: XOR reduction, inverted for odd parity.
module parity_calc
  import uart_tx_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             par_typ_i,
  output logic             par_bit_o
);
  always_comb begin
    par_bit_o = ^data_i;
    unique case (par_typ_i)
      ParEven: par_bit_o = ^data_i;
      ParOdd:  par_bit_o = ~^data_i;
    endcase
  end
endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: one-entry holding register, start/data/parity/stop FSM,
// serializer load pulse and serial line mux.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_ctrl,
  input  logic             rst_ctrl,
  uart_tx_ctrl_if.slave    in_if,
  input  logic             ser_done,
  input  logic             ser_data,
  output logic             ser_en,
  output logic [WIDTH-1:0] P_DATA_ser,
  output logic             TX_OUT,
  output logic             busy,
  output logic             tx_done,
  output logic             ser_err
);
  localparam int unsigned     CntW    = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  tx_state_e        state_q, state_d;
  logic             hold_valid_q, hold_valid_d;
  logic [WIDTH-1:0] hold_data_q, hold_data_d;
  logic             hold_par_en_q, hold_par_en_d;
  logic             hold_par_typ_q, hold_par_typ_d;
  logic             data_ready_q;
  logic [WIDTH-1:0] frame_q, frame_d;
  logic             par_en_r_q, par_en_r_d;
  logic             par_bit_q, par_bit_d;
  logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic             ser_en_q, ser_en_d;
  logic             hold_par_bit;
  logic             push, pop;

  parity_calc #(
    .WIDTH(WIDTH)
  ) u_parity_calc (
    .data_i   (hold_data_q),
    .par_typ_i(hold_par_typ_q),
    .par_bit_o(hold_par_bit)
  );

  always_comb begin
    state_d        = state_q;
    hold_valid_d   = hold_valid_q;
    hold_data_d    = hold_data_q;
    hold_par_en_d  = hold_par_en_q;
    hold_par_typ_d = hold_par_typ_q;
    frame_d        = frame_q;
    par_en_r_d     = par_en_r_q;
    par_bit_d      = par_bit_q;
    bit_cnt_d      = bit_cnt_q;
    ser_err        = 1'b0;

    // Push needs an empty register and pop a full one, so they are mutually exclusive.
    push = in_if.data_valid & data_ready_q;
    pop  = hold_valid_q & ((state_q == StIdle) | (state_q == StStop));

    if (push) begin
      hold_valid_d   = 1'b1;
      hold_data_d    = in_if.P_DATA;
      hold_par_en_d  = in_if.par_en;
      hold_par_typ_d = in_if.par_typ;
    end
    if (pop) begin
      hold_valid_d = 1'b0;
      frame_d      = hold_data_q;
      par_en_r_d   = hold_par_en_q;
      par_bit_d    = hold_par_bit;
    end
    ser_en_d = pop;

    unique case (state_q)
      StIdle: if (pop) state_d = StStart;
      StStart: begin
        bit_cnt_d = '0;
        state_d   = StData;
      end
      StData: begin
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (ser_done || (bit_cnt_q == LastBit)) begin
          ser_err = ~ser_done;
          state_d = par_en_r_q ? StParity : StStop;
        end
      end
      StParity: state_d = StStop;
      StStop:   state_d = pop ? StStart : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_ctrl) begin
    if (rst_ctrl) begin
      state_q        <= StIdle;
      hold_valid_q   <= 1'b0;
      hold_data_q    <= '0;
      hold_par_en_q  <= 1'b0;
      hold_par_typ_q <= 1'b0;
      data_ready_q   <= 1'b1;
      frame_q        <= '0;
      par_en_r_q     <= 1'b0;
      par_bit_q      <= 1'b0;
      bit_cnt_q      <= '0;
      ser_en_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      hold_valid_q   <= hold_valid_d;
      hold_data_q    <= hold_data_d;
      hold_par_en_q  <= hold_par_en_d;
      hold_par_typ_q <= hold_par_typ_d;
      data_ready_q   <= ~hold_valid_d;
      frame_q        <= frame_d;
      par_en_r_q     <= par_en_r_d;
      par_bit_q      <= par_bit_d;
      bit_cnt_q      <= bit_cnt_d;
      ser_en_q       <= ser_en_d;
    end
  end

  always_comb begin
    TX_OUT = 1'b1;
    unique case (tx_sel_of(state_q))
      TxSelStart:  TX_OUT = 1'b0;
      TxSelData:   TX_OUT = ser_data;
      TxSelParity: TX_OUT = par_bit_q;
      TxSelStop:   TX_OUT = 1'b1;
    endcase
  end

  assign in_if.data_ready = data_ready_q;
  assign ser_en           = ser_en_q;
  assign P_DATA_ser       = frame_q;
  assign busy             = (state_q != StIdle) | hold_valid_q;
  assign tx_done          = (state_q == StStop);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: directed frame table, back-to-back, serializer fault,
// mid-frame reset, and randomized traffic checked by a line-level receiver model.
module tb_uart_tx_ctrl;
  localparam int unsigned W  = 8;
  localparam int          NR = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_ctrl_if #(.WIDTH(W)) bus ();

  logic         ser_done, ser_data, ser_en, TX_OUT, busy, tx_done, ser_err;
  logic [W-1:0] P_DATA_ser;

  uart_tx_ctrl #(
    .WIDTH(W)
  ) dut (
    .clk_ctrl  (clk),
    .rst_ctrl  (rst),
    .in_if     (bus),
    .ser_done  (ser_done),
    .ser_data  (ser_data),
    .ser_en    (ser_en),
    .P_DATA_ser(P_DATA_ser),
    .TX_OUT    (TX_OUT),
    .busy      (busy),
    .tx_done   (tx_done),
    .ser_err   (ser_err)
  );

  // Serializer model: bit k in the k-th cycle after the load pulse, done on the last bit.
  logic [W-1:0] sreg = '0;
  int           scnt = 0;
  bit           sactive = 1'b0;
  bit           done_low = 1'b0;
  always @(posedge clk) begin
    if (ser_en === 1'b1) begin
      sreg    <= P_DATA_ser;
      scnt    <= 0;
      sactive <= 1'b1;
    end else if (sactive) begin
      if (scnt == W - 1) sactive <= 1'b0;
      scnt <= scnt + 1;
    end
  end
  assign ser_data = sactive ? sreg[scnt] : 1'b1;
  assign ser_done = sactive && (scnt == W - 1) && !done_low;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  bit exp_q[$];

  // Reference frame: start 0, data LSB first, parity making the ones count even/odd, stop 1.
  task automatic push_frame(input logic [7:0] b, input bit pe, input bit pt);
    int ones;
    ones = $countones(b);
    exp_q.push_back(1'b0);
    for (int i = 0; i < W; i++) exp_q.push_back(b[i]);
    if (pe) exp_q.push_back(pt ? ((ones % 2) == 0) : ((ones % 2) == 1));
    exp_q.push_back(1'b1);
  endtask

  // Expected line bits are written left-to-right in cycle order; cycle i is bits[len-1-i].
  typedef struct {
    logic [7:0]  data;
    bit          pe;
    bit          pt;
    logic [11:0] bits;
    int          len;
  } vec_t;

  typedef struct {
    logic [7:0] b;
    bit         pe;
    bit         pt;
  } item_t;

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t   vecs[7];
    item_t  sent_q[$];
    item_t  cur, rx_item;
    logic [7:0] b2b[3];
    int     acc[3];
    int     idx, nsent, nrecv, rx_pos;
    bit     offering;

    vecs[0] = '{8'hA5, 1'b1, 1'b0, 12'b01010010101, 11};
    vecs[1] = '{8'h01, 1'b1, 1'b1, 12'b01000000001, 11};
    vecs[2] = '{8'h01, 1'b1, 1'b0, 12'b01000000011, 11};
    vecs[3] = '{8'hFF, 1'b0, 1'b0, 12'b0111111111,  10};
    vecs[4] = '{8'h00, 1'b1, 1'b1, 12'b00000000011, 11};
    vecs[5] = '{8'h3C, 1'b1, 1'b0, 12'b00011110001, 11};
    vecs[6] = '{8'h80, 1'b0, 1'b1, 12'b0000000011,  10};

    bus.P_DATA = '0;
    bus.data_valid = 1'b0;
    bus.par_en = 1'b0;
    bus.par_typ = 1'b0;

    // Reset held for two cycles.
    tick();
    tick();
    chk("rst_tx", TX_OUT, 1);
    chk("rst_ready", bus.data_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ser_en", ser_en, 0);
    chk("rst_tx_done", tx_done, 0);
    chk("rst_ser_err", ser_err, 0);
    chk("rst_pdata_ser", P_DATA_ser, 0);
    rst = 1'b0;

    // Directed single frames from an idle block.
    for (int v = 0; v < 7; v++) begin
      bus.P_DATA = vecs[v].data;
      bus.par_en = vecs[v].pe;
      bus.par_typ = vecs[v].pt;
      bus.data_valid = 1'b1;
      chk($sformatf("v%0d_ready", v), bus.data_ready, 1);
      tick();
      bus.data_valid = 1'b0;
      chk($sformatf("v%0d_busy_c1", v), busy, 1);
      chk($sformatf("v%0d_tx_c1", v), TX_OUT, 1);
      tick();
      chk($sformatf("v%0d_ser_en", v), ser_en, 1);
      chk($sformatf("v%0d_pdata_ser", v), P_DATA_ser, vecs[v].data);
      for (int i = 0; i < vecs[v].len; i++) begin
        chk($sformatf("v%0d_bit%0d", v, i), TX_OUT, vecs[v].bits[vecs[v].len - 1 - i]);
        chk($sformatf("v%0d_done%0d", v, i), tx_done, (i == vecs[v].len - 1));
        chk($sformatf("v%0d_err%0d", v, i), ser_err, 0);
        tick();
      end
      chk($sformatf("v%0d_idle_busy", v), busy, 0);
      chk($sformatf("v%0d_idle_tx", v), TX_OUT, 1);
    end

    // Back-to-back: three bytes offered continuously.
    b2b[0] = 8'h11;
    b2b[1] = 8'h22;
    b2b[2] = 8'h33;
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      push_frame(b2b[k], 1'b0, 1'b0);
      acc[k] = -1;
    end
    idx = 0;
    bus.par_en = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (idx < 3) begin
        bus.P_DATA = b2b[idx];
        bus.data_valid = 1'b1;
        if (bus.data_ready === 1'b1) begin
          acc[idx] = c;
          idx++;
        end
      end else begin
        bus.data_valid = 1'b0;
      end
      if (c >= 2 && c < 32) chk($sformatf("b2b_c%0d", c), TX_OUT, exp_q[c - 2]);
      tick();
    end
    bus.data_valid = 1'b0;
    chk("b2b_acc0", acc[0], 0);
    chk("b2b_acc1", acc[1], 2);
    chk("b2b_acc2", acc[2], 12);
    chk("b2b_busy_end", busy, 0);

    // Serializer never raises done: error in the last data cycle, then stop.
    done_low = 1'b1;
    bus.P_DATA = 8'h5A;
    bus.par_en = 1'b0;
    bus.data_valid = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (c == 1) bus.data_valid = 1'b0;
      if (c >= 2) begin
        chk($sformatf("err_c%0d", c), ser_err, (c == 10));
        chk($sformatf("err_done_c%0d", c), tx_done, (c == 11));
      end
      tick();
    end
    chk("err_idle", busy, 0);
    done_low = 1'b0;

    // Reset in DATA cycle 4 with a byte pending.
    bus.P_DATA = 8'hC3;
    bus.par_en = 1'b1;
    bus.par_typ = 1'b0;
    bus.data_valid = 1'b1;
    tick();
    bus.data_valid = 1'b0;
    tick();
    bus.P_DATA = 8'h7E;
    bus.data_valid = 1'b1;
    chk("mr_ready_c2", bus.data_ready, 1);
    tick();
    bus.data_valid = 1'b0;
    for (int c = 3; c < 7; c++) tick();
    chk("mr_data4", TX_OUT, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_tx", TX_OUT, 1);
    chk("mr_ser_en", ser_en, 0);
    chk("mr_busy", busy, 0);
    chk("mr_ready", bus.data_ready, 1);
    for (int c = 0; c < 15; c++) begin
      tick();
      chk($sformatf("mr_lost_tx%0d", c), TX_OUT, 1);
      chk($sformatf("mr_lost_en%0d", c), ser_en, 0);
    end

    // Randomized traffic decoded off the line by a receiver model.
    nsent = 0;
    nrecv = 0;
    rx_pos = -1;
    offering = 1'b0;
    cur = '{8'h00, 1'b0, 1'b0};
    for (int c = 0; c < 4000 && nrecv < NR; c++) begin
      if (rx_pos < 0) begin
        if (TX_OUT !== 1'b1) begin
          if (sent_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rnd_spurious_start: got %b expected 1", TX_OUT);
          end else begin
            rx_item = sent_q.pop_front();
            exp_q.delete();
            push_frame(rx_item.b, rx_item.pe, rx_item.pt);
            rx_pos = 1;
          end
        end
      end else begin
        chk($sformatf("rnd_f%0d_bit%0d", nrecv, rx_pos), TX_OUT, exp_q[rx_pos]);
        chk($sformatf("rnd_f%0d_done%0d", nrecv, rx_pos), tx_done, (rx_pos == exp_q.size() - 1));
        rx_pos++;
        if (rx_pos == exp_q.size()) begin
          rx_pos = -1;
          nrecv++;
        end
      end
      if (ser_err !== 1'b0) chk("rnd_ser_err", ser_err, 0);

      if (!offering && nsent < NR && $urandom_range(0, 3) != 0) begin
        cur.b = 8'($urandom);
        cur.pe = 1'($urandom_range(0, 1));
        cur.pt = 1'($urandom_range(0, 1));
        offering = 1'b1;
      end
      bus.data_valid = offering;
      bus.P_DATA = cur.b;
      bus.par_en = cur.pe;
      bus.par_typ = cur.pt;
      if (offering && bus.data_ready === 1'b1) begin
        sent_q.push_back(cur);
        nsent++;
        offering = 1'b0;
      end
      tick();
    end
    bus.data_valid = 1'b0;
    chk("rnd_all_received", nrecv, NR);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Frame sequencer for the UART transmit path. Accepts parallel bytes through a valid/ready handshake and buffers one pending byte. Computes optional even/odd parity and drives the existing serializer (`ser_en` / `ser_done` / `ser_data`). Muxes start, data, parity and stop bits onto `TX_OUT`, and supports back-to-back frames with no idle gap.

## Interface
- `WIDTH`, 8, data bits per frame (LSB first); bit counter width is clog2(WIDTH+1).
- `clk_ctrl` in 1: the single clock, shared with the serializer.
- `rst_ctrl` in 1: synchronous, active-high reset.
- `P_DATA` in WIDTH: byte to transmit.
- `data_valid` in 1: `P_DATA`, `par_en` and `par_typ` are valid.
- `data_ready` out 1: holding register empty; a transfer occurs on `data_valid & data_ready`.
- `par_en` in 1: append a parity bit, sampled with the byte.
- `par_typ` in 1: 0 = even, 1 = odd; sampled with the byte.
- `ser_done` in 1: serializer's last-bit flag.
- `ser_data` in 1: serializer's serial output.
- `ser_en` out 1: one-cycle load pulse to the serializer.
- `P_DATA_ser` out WIDTH: frame byte to the serializer, held stable for the whole frame.
- `TX_OUT` out 1: serial line.
- `busy` out 1: state ≠ IDLE or holding register full.
- `tx_done` out 1: one-cycle pulse in the final STOP cycle.
- `ser_err` out 1: one-cycle pulse when `ser_done` is missing.

## Operation
- Holding register: a one-entry {byte, `par_en`, `par_typ`} with a `hold_valid` flag.
  - `data_ready` = ~`hold_valid`, registered.
  - A push is only possible while the register is empty, so push and pop never coincide.
- Pop occurs in IDLE when `hold_valid`, or in STOP when `hold_valid`. A pop:
  - loads the frame registers (`P_DATA_ser`, `par_en_r`, `par_bit`);
  - sets `ser_en` for the next cycle;
  - enters START.
- Parity: `par_bit` = ^byte for even, ~^byte for odd. It is computed at pop time and registered.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: `TX_OUT`=1. Goes to START on pop.
  - START: `TX_OUT`=0, `ser_en`=1, `bit_cnt` cleared. Goes to DATA unconditionally.
  - DATA: `TX_OUT`=`ser_data`, `bit_cnt`++ each cycle.
    - Exits when `ser_done`=1, or when `bit_cnt` reaches WIDTH-1 without `ser_done`; in the latter case `ser_err` pulses in the exit cycle.
    - Goes to PARITY if `par_en_r`, else STOP.
  - PARITY: `TX_OUT`=`par_bit`. Goes to STOP.
  - STOP: `TX_OUT`=1, `tx_done`=1. Goes to START on pop, else IDLE.
- `TX_OUT` is combinational from registered state, `par_bit` and `ser_data`; it has no extra register stage.
- `ser_en` is asserted only during START cycles.

## Timing
- Reset values:
  - state=IDLE, `hold_valid`=0, `data_ready`=1;
  - `ser_en`=0, `TX_OUT`=1, `busy`=0, `tx_done`=0, `ser_err`=0;
  - `P_DATA_ser`=0, `par_bit`=0, `bit_cnt`=0.
- Cycle numbering from an idle block:
  - Handshake sampled at the end of cycle 0.
  - Cycle 1: `hold_valid`=1, pop.
  - Cycle 2: START.
  - Cycles 3..2+WIDTH: data bits, b0 first.
  - Cycle 3+WIDTH: parity, if enabled.
  - Next cycle: STOP.
- Frame length is WIDTH+2 cycles without parity and WIDTH+3 with parity.
- Serializer contract: bit k is on `ser_data` in DATA cycle k, and `ser_done` is high in DATA cycle WIDTH-1.
- Back-to-back: a byte held at STOP gives START in the very next cycle. `data_ready` rises the cycle after the pop.
- Reset mid-frame, effective on the next edge:
  - `TX_OUT`=1, the pending byte is discarded, `ser_en`=0;
  - serializer output is ignored in IDLE.
- `data_valid` while `data_ready`=0: no effect. The source must hold the byte.

## Structure
- Shared package `uart_tx_pkg`:
  - state encodings;
  - `TX_OUT` select codes (START=2'b00, DATA=2'b01, PARITY=2'b10, STOP=2'b11);
  - parity type constants EVEN=0, ODD=1.
- One natural sub-module, `parity_calc`: WIDTH-bit reduction plus type select, instantiated on the holding-register output.
- The FSM, holding register and output mux stay in `uart_tx_ctrl`.
- The serializer is instantiated beside this block at the TX top, not inside it.

## Test plan
- Reset: assert `rst_ctrl` for 2 cycles → `TX_OUT`=1, `data_ready`=1, `busy`=0, `ser_en`=0, with no `tx_done` or `ser_err`.
- Byte 0xA5, `par_en`=1, `par_typ`=0 → `TX_OUT` from cycle 2 reads 0,1,0,1,0,0,1,0,1,0,1 (11 cycles), with `tx_done` on the stop bit. Then IDLE, `busy`=0.
- Byte 0x01 with odd parity → parity bit 0. The same byte with even parity → parity bit 1.
- Byte 0xFF, `par_en`=0 → 10-cycle frame 0,1×8,1, with no PARITY state visited.
- Three bytes 0x11, 0x22, 0x33 offered continuously:
  - 0x22 is accepted during frame 1;
  - frame 2 START directly follows frame 1 STOP with no idle cycle;
  - 0x33 stalls (`data_ready`=0) until the pop.
- Serializer model with `ser_done` tied low → `ser_err` pulses in DATA cycle WIDTH-1, then STOP proceeds. Separately, reset asserted in DATA cycle 4 → `TX_OUT`=1 in the next cycle and the pending byte is lost.
